jk_excitation_driver: RTL and testbench
=======================================

Name: jk_excitation_driver

Overview:
- Drives a bank of WIDTH external JK flip-flops, each built from a D flip-flop, to a requested target state. This is the stimulus end of the clk/rst/J/K/Q interface.
- Accepts target words over a valid/ready handshake and computes per-bit J/K excitation from the current Q feedback.
- Pulses J/K for one cycle, waits for the flops to settle, then checks Q against the target.
- Retries on mismatch and reports done or error. Used as the reusable front end for JK-register datapaths and their self-checking benches.

Parameters:
- WIDTH, 4, number of JK flip-flops driven (≥1).
- SETTLE, 1, cycles from J/K deassertion to the Q comparison (≥1).
- MAX_RETRY, 2, re-drive attempts after the first mismatch before error (0–15).
- USE_TOGGLE, 0, 0: changing bits use set/reset (J=1,K=0 / J=0,K=1); 1: changing bits use toggle (J=1,K=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tgt_valid  input  1  target word offered.
- tgt_ready  output  1  block can accept a target; high only in IDLE and not in reset.
- tgt_data  input  WIDTH  requested Q value.
- q_fb  input  WIDTH  Q outputs of the driven flip-flop bank.
- j_out  output  WIDTH  registered J drive.
- k_out  output  WIDTH  registered K drive.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: q_fb matched the target.
- err  output  1  one-cycle pulse: retries exhausted.
- err_mask  output  WIDTH  q_fb XOR target at the failing compare; held until the next accept.
- xfer_cnt  output  8  count of successful transfers, saturating at 255.

Behaviour:
- Reset, applied at any edge in any state:
  - state=IDLE.
  - j_out=k_out=0, done=err=0, err_mask=0, xfer_cnt=0.
  - Retry and settle counters cleared; target register cleared.
  - tgt_ready=0 while rst is high.
  - A transaction in flight is abandoned with no done or err.
- Excitation function exc(t,q), per bit:
  - t==q: J=0, K=0 (hold).
  - t=1, q=0: J=1, K=0 (USE_TOGGLE=0) or J=1, K=1 (USE_TOGGLE=1).
  - t=0, q=1: J=0, K=1 (USE_TOGGLE=0) or J=1, K=1 (USE_TOGGLE=1).
  - J=K=1 never appears on a bit that is already correct.
- States: IDLE, DRIVE, SETTLE.
- IDLE:
  - Handshake fires when tgt_valid && tgt_ready at an edge.
  - At that edge: tgt_reg<=tgt_data; j_out,k_out<=exc(tgt_data,q_fb); retry<=0; err_mask<=0; go to DRIVE.
  - With no handshake, j_out=k_out=0.
- DRIVE:
  - Lasts exactly one cycle.
  - At the next edge: j_out=k_out<=0; settle counter<=0; go to SETTLE.
- SETTLE:
  - The settle counter increments each edge.
  - At the edge where the counter equals SETTLE-1, q_fb is compared with tgt_reg:
    - Match: done<=1 for one cycle; xfer_cnt increments, saturating; go to IDLE.
    - Mismatch and retry<MAX_RETRY: retry++; j_out,k_out<=exc(tgt_reg,q_fb); go to DRIVE.
    - Mismatch and retry==MAX_RETRY: err<=1 for one cycle; err_mask<=q_fb^tgt_reg; go to IDLE.
- Latency:
  - With no retries, done asserts (1+SETTLE) edges after the accept edge.
  - With SETTLE=1, done is visible in the cycle after accept edge +2.
- Back-to-back operation:
  - tgt_ready rises in the same cycle that done or err is high.
  - A new accept may occur on the edge that ends the done cycle.
- A target equal to the current q_fb is still accepted. It produces J=K=0 for one DRIVE cycle, then done.
- tgt_data changes while busy are ignored; tgt_reg is held.
- done and err are never high in the same cycle.

Test Plan:
1. rst=1 for 2 cycles, then release with WIDTH=4, q_fb=0000 → tgt_ready=1; j_out=k_out=0000; done=err=0; xfer_cnt=0.
2. USE_TOGGLE=0 with an ideal JK model on q_fb, Q=0000, target 1010 → DRIVE cycle has j_out=1010, k_out=0000; done at accept+2; Q=1010; xfer_cnt=1. Next target 0110 → j_out=0100, k_out=1000; done.
3. Same sequence with USE_TOGGLE=1 → for 0000→1010: j_out=k_out=1010; for 1010→0110: j_out=k_out=1100; Q reaches the target; done.
4. q_fb bit 0 stuck at 0, MAX_RETRY=2, target 0001 → three DRIVE cycles, each with j_out=0001; then err pulse; err_mask=0001; no done; tgt_ready returns to 1.
5. rst asserted during SETTLE → at the next edge state=IDLE, j_out=k_out=0, no done or err, xfer_cnt=0.
6. tgt_valid held high with five targets queued back-to-back, SETTLE=3 → each done arrives 4 edges after its accept; xfer_cnt=5. A target equal to the current Q gives j_out=k_out=0 and still gives done.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//
// Stimulus front end for a bank of WIDTH external JK flip-flops, where each
// flop is built from a D flip-flop. A target word is accepted over a
// valid/ready handshake. The block computes per-bit J/K excitation from the
// current Q feedback and drives J/K for one cycle. It then waits SETTLE
// cycles and compares Q with the target. On a mismatch it re-drives up to
// MAX_RETRY times. It then pulses done on a match, or err when the retries
// are exhausted.
//
// Parameters:
//   WIDTH      number of JK flip-flops driven (>= 1)
//   SETTLE     cycles from J/K deassertion to the Q comparison (>= 1)
//   MAX_RETRY  re-drive attempts after the first mismatch (0..15)
//   USE_TOGGLE 0: changing bits use set/reset; 1: changing bits use toggle
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   tgt_valid  target word offered
//   tgt_ready  target can be accepted (IDLE and not in reset)
//   tgt_data   requested Q value
//   q_fb       Q outputs of the driven flip-flop bank
//   j_out      registered J drive
//   k_out      registered K drive
//   busy       high in any state other than IDLE
//   done       one-cycle pulse: Q matched the target
//   err        one-cycle pulse: retries exhausted
//   err_mask   q_fb ^ target at the failing compare, held until next accept
//   xfer_cnt   successful transfer count, saturating at 255

module jk_excitation_driver #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned SETTLE     = 1,
    parameter int unsigned MAX_RETRY  = 2,
    parameter int unsigned USE_TOGGLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    output logic [7:0]       xfer_cnt
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [3:0]    RETRY_LAST  = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] tgt_reg;
    logic [3:0]       retry;
    logic [SW-1:0]    settle_cnt;

    // Bits that already hold their target value get J=K=0, so a toggle is
    // only ever applied to a bit that has to change.
    function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] t,
                                               input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] diff;
        diff = t ^ q;
        return (USE_TOGGLE != 0) ? diff : (diff & t);
    endfunction

    function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] t,
                                               input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] diff;
        diff = t ^ q;
        return (USE_TOGGLE != 0) ? diff : (diff & ~t);
    endfunction

    // The rst term lets tgt_ready drop in the same cycle that reset is
    // raised, so the upstream never sees a handshake during reset.
    always_comb begin
        tgt_ready = (state == ST_IDLE) && !rst;
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tgt_reg    <= '0;
            retry      <= '0;
            settle_cnt <= '0;
            j_out      <= '0;
            k_out      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_mask   <= '0;
            xfer_cnt   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    j_out <= '0;
                    k_out <= '0;
                    if (tgt_valid && tgt_ready) begin
                        tgt_reg  <= tgt_data;
                        j_out    <= exc_j(tgt_data, q_fb);
                        k_out    <= exc_k(tgt_data, q_fb);
                        retry    <= '0;
                        err_mask <= '0;
                        state    <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    j_out      <= '0;
                    k_out      <= '0;
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        if (q_fb == tgt_reg) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                            if (xfer_cnt != 8'hFF) begin
                                xfer_cnt <= xfer_cnt + 8'd1;
                            end
                        end else if (retry != RETRY_LAST) begin
                            retry <= retry + 4'd1;
                            j_out <= exc_j(tgt_reg, q_fb);
                            k_out <= exc_k(tgt_reg, q_fb);
                            state <= ST_DRIVE;
                        end else begin
                            err      <= 1'b1;
                            err_mask <= q_fb ^ tgt_reg;
                            state    <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       env_clr;
    logic       tgt_valid [2];
    logic [3:0] tgt_data  [2];
    logic       tgt_ready [2];
    logic [3:0] q_fb      [2];
    logic [3:0] j_out     [2];
    logic [3:0] k_out     [2];
    logic       busy      [2];
    logic       done      [2];
    logic       err       [2];
    logic [3:0] err_mask  [2];
    logic [7:0] xfer_cnt  [2];

    // External flop bank (physical Q) and stuck-at faults on its outputs
    logic [3:0] qreg [2];
    logic [3:0] s0   [2];
    logic [3:0] s1   [2];

    // Reference model state
    logic [3:0] mq      [2];
    int         exp_cnt [2];
    int         settle_p [2] = '{1, 3};
    int         retry_p  [2] = '{2, 1};
    int         tog_p    [2] = '{0, 1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign q_fb[0] = (qreg[0] & ~s0[0]) | s1[0];
    assign q_fb[1] = (qreg[1] & ~s0[1]) | s1[1];

    jk_excitation_driver #(
        .WIDTH(4), .SETTLE(1), .MAX_RETRY(2), .USE_TOGGLE(0)
    ) dut_a (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid[0]), .tgt_ready(tgt_ready[0]),
        .tgt_data(tgt_data[0]), .q_fb(q_fb[0]), .j_out(j_out[0]), .k_out(k_out[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .err_mask(err_mask[0]),
        .xfer_cnt(xfer_cnt[0])
    );

    jk_excitation_driver #(
        .WIDTH(4), .SETTLE(3), .MAX_RETRY(1), .USE_TOGGLE(1)
    ) dut_b (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid[1]), .tgt_ready(tgt_ready[1]),
        .tgt_data(tgt_data[1]), .q_fb(q_fb[1]), .j_out(j_out[1]), .k_out(k_out[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .err_mask(err_mask[1]),
        .xfer_cnt(xfer_cnt[1])
    );

    function automatic logic [3:0] jk_step(input logic [3:0] q, input logic [3:0] j,
                                           input logic [3:0] k);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            if (j[i] && k[i])  r[i] = ~q[i];
            else if (j[i])     r[i] = 1'b1;
            else if (k[i])     r[i] = 1'b0;
            else               r[i] = q[i];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (env_clr) qreg[d] <= 4'b0000;
            else         qreg[d] <= jk_step(qreg[d], j_out[d], k_out[d]);
        end
    end

    // Excitation table: set bit -> J=1 (K also 1 when toggling);
    // clear bit -> K=1 (J also 1 when toggling); unchanged -> hold.
    function automatic logic [3:0] exp_j(input int d, input logic [3:0] t, input logic [3:0] q);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            if (t[i] == q[i]) r[i] = 1'b0;
            else if (t[i])    r[i] = 1'b1;
            else              r[i] = (tog_p[d] != 0);
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_k(input int d, input logic [3:0] t, input logic [3:0] q);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            if (t[i] == q[i]) r[i] = 1'b0;
            else if (!t[i])   r[i] = 1'b1;
            else              r[i] = (tog_p[d] != 0);
        end
        return r;
    endfunction

    function automatic logic [3:0] seen_q(input int d, input logic [3:0] q);
        return (q & ~s0[d]) | s1[d];
    endfunction

    // Entered at a negedge with the DUT idle (or in its done/err cycle);
    // returns at the negedge of the done/err cycle.
    task automatic do_txn(input int d, input logic [3:0] t, input bit keep);
        logic [3:0] qo, ej, ek;
        int tries;
        bit fin;
        tgt_valid[d] = 1'b1;
        tgt_data[d]  = t;
        checks++;
        if (tgt_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_offer dut%0d got %b want 1", d, tgt_ready[d]);
        end
        qo    = seen_q(d, mq[d]);
        ej    = exp_j(d, t, qo);
        ek    = exp_k(d, t, qo);
        tries = 0;
        fin   = 1'b0;
        @(negedge clk);
        tgt_valid[d] = keep;
        tgt_data[d]  = 4'($urandom);
        while (!fin) begin
            checks++;
            if (j_out[d] !== ej || k_out[d] !== ek || busy[d] !== 1'b1 ||
                done[d] !== 1'b0 || err[d] !== 1'b0 || err_mask[d] !== 4'b0000) begin
                errors++;
                $display("FAIL drive dut%0d tgt=%b j=%b k=%b busy=%b done=%b err=%b mask=%b want j=%b k=%b busy=1 done=0 err=0 mask=0000",
                         d, t, j_out[d], k_out[d], busy[d], done[d], err[d], err_mask[d], ej, ek);
            end
            mq[d] = jk_step(mq[d], ej, ek);
            repeat (settle_p[d]) begin
                @(negedge clk);
                tgt_data[d] = 4'($urandom);
                checks++;
                if (j_out[d] !== 4'b0000 || k_out[d] !== 4'b0000 || busy[d] !== 1'b1 ||
                    done[d] !== 1'b0 || err[d] !== 1'b0 || tgt_ready[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL settle dut%0d j=%b k=%b busy=%b done=%b err=%b ready=%b want 0000 0000 1 0 0 0",
                             d, j_out[d], k_out[d], busy[d], done[d], err[d], tgt_ready[d]);
                end
            end
            @(negedge clk);
            qo = seen_q(d, mq[d]);
            if (qo == t) begin
                if (exp_cnt[d] < 255) exp_cnt[d]++;
                checks++;
                if (done[d] !== 1'b1 || err[d] !== 1'b0 || busy[d] !== 1'b0 ||
                    tgt_ready[d] !== 1'b1 || xfer_cnt[d] !== 8'(exp_cnt[d])) begin
                    errors++;
                    $display("FAIL done dut%0d done=%b err=%b busy=%b ready=%b cnt=%0d want 1 0 0 1 cnt=%0d",
                             d, done[d], err[d], busy[d], tgt_ready[d], xfer_cnt[d], exp_cnt[d]);
                end
                fin = 1'b1;
            end else if (tries < retry_p[d]) begin
                tries++;
                ej = exp_j(d, t, qo);
                ek = exp_k(d, t, qo);
            end else begin
                checks++;
                if (err[d] !== 1'b1 || done[d] !== 1'b0 || busy[d] !== 1'b0 ||
                    tgt_ready[d] !== 1'b1 || err_mask[d] !== (qo ^ t) ||
                    xfer_cnt[d] !== 8'(exp_cnt[d])) begin
                    errors++;
                    $display("FAIL err dut%0d err=%b done=%b busy=%b ready=%b mask=%b cnt=%0d want 1 0 0 1 mask=%b cnt=%0d",
                             d, err[d], done[d], busy[d], tgt_ready[d], err_mask[d], xfer_cnt[d], qo ^ t, exp_cnt[d]);
                end
                fin = 1'b1;
            end
        end
    endtask

    task automatic check_idle_after_reset(input string name);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (tgt_ready[d] !== 1'b1 || j_out[d] !== 4'b0000 || k_out[d] !== 4'b0000 ||
                done[d] !== 1'b0 || err[d] !== 1'b0 || busy[d] !== 1'b0 ||
                err_mask[d] !== 4'b0000 || xfer_cnt[d] !== 8'd0) begin
                errors++;
                $display("FAIL %s dut%0d ready=%b j=%b k=%b done=%b err=%b busy=%b mask=%b cnt=%0d want 1 0000 0000 0 0 0 0000 0",
                         name, d, tgt_ready[d], j_out[d], k_out[d], done[d], err[d], busy[d], err_mask[d], xfer_cnt[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        env_clr = 1'b1;
        for (int d = 0; d < 2; d++) begin
            tgt_valid[d] = 1'b0;
            tgt_data[d]  = 4'b0000;
            s0[d] = 4'b0000;
            s1[d] = 4'b0000;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (tgt_ready[d] !== 1'b0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL in_reset dut%0d ready=%b busy=%b want 0 0", d, tgt_ready[d], busy[d]);
            end
            mq[d] = 4'b0000;
            exp_cnt[d] = 0;
        end
        rst = 1'b0;
        env_clr = 1'b0;
        @(negedge clk);
        check_idle_after_reset("reset_release");
    endtask

    task automatic test_set_reset();
        do_txn(0, 4'b1010, 1'b0);
        do_txn(0, 4'b0110, 1'b0);
        checks++;
        if (q_fb[0] !== 4'b0110) begin
            errors++;
            $display("FAIL set_reset_q got %b want 0110", q_fb[0]);
        end
    endtask

    task automatic test_toggle();
        do_txn(1, 4'b0000, 1'b0);
        do_txn(1, 4'b1010, 1'b0);
        do_txn(1, 4'b0110, 1'b0);
        checks++;
        if (q_fb[1] !== 4'b0110) begin
            errors++;
            $display("FAIL toggle_q got %b want 0110", q_fb[1]);
        end
    endtask

    task automatic test_retry_err();
        do_txn(0, 4'b0000, 1'b0);
        s0[0] = 4'b0001;
        do_txn(0, 4'b0001, 1'b0);
        @(negedge clk);
        checks++;
        if (err_mask[0] !== 4'b0001 || err[0] !== 1'b0 || done[0] !== 1'b0 || tgt_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_hold mask=%b err=%b done=%b ready=%b want 0001 0 0 1",
                     err_mask[0], err[0], done[0], tgt_ready[0]);
        end
        s0[0] = 4'b0000;
    endtask

    task automatic test_reset_in_settle();
        logic [3:0] t;
        t = ~seen_q(1, mq[1]);
        tgt_valid[1] = 1'b1;
        tgt_data[1]  = t;
        @(negedge clk);
        tgt_valid[1] = 1'b0;
        mq[1] = jk_step(mq[1], exp_j(1, t, seen_q(1, mq[1])), exp_k(1, t, seen_q(1, mq[1])));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || j_out[d] !== 4'b0000 || k_out[d] !== 4'b0000 ||
                done[d] !== 1'b0 || err[d] !== 1'b0 || xfer_cnt[d] !== 8'd0 || tgt_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid dut%0d busy=%b j=%b k=%b done=%b err=%b cnt=%0d ready=%b want 0 0000 0000 0 0 0 0",
                         d, busy[d], j_out[d], k_out[d], done[d], err[d], xfer_cnt[d], tgt_ready[d]);
            end
            exp_cnt[d] = 0;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_idle_after_reset("after_reset_mid");
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] t [5];
        for (int i = 0; i < 5; i++) t[i] = 4'($urandom);
        t[2] = t[1];
        for (int i = 0; i < 5; i++) do_txn(1, t[i], 1'b1);
        tgt_valid[1] = 1'b0;
        checks++;
        if (xfer_cnt[1] !== 8'd5) begin
            errors++;
            $display("FAIL b2b_count got %0d want 5", xfer_cnt[1]);
        end
        @(negedge clk);
        checks++;
        if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle busy=%b done=%b want 0 0", busy[1], done[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 3) == 0) begin
                    s0[d] = 4'($urandom & $urandom & $urandom);
                    s1[d] = 4'($urandom & $urandom & $urandom) & ~s0[d];
                end else begin
                    s0[d] = 4'b0000;
                    s1[d] = 4'b0000;
                end
                do_txn(d, 4'($urandom), 1'b0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        s0[0] = 4'b0000; s1[0] = 4'b0000;
        s0[1] = 4'b0000; s1[1] = 4'b0000;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_set_reset();
        test_toggle();
        test_retry_err();
        test_reset_in_settle();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
